fog_err_demod: RTL and testbench
================================

Name: fog_err_demod

Overview:
- Closed-loop FOG error demodulator: the producer side of the step generator's error/trigger interface.
- Drives the square-wave bias modulation (o_mod) and accumulates ADC samples over each high and low half-period.
- Once per full modulation period, emits the signed half-period difference as o_err, qualified by a 1-cycle o_trig pulse.
- o_err/o_trig connect directly to the feedback step generator's i_err/i_trig.

Parameters:
ADC_W, 14, signed ADC sample width
DATA_W, 32, width of o_err and accumulators

Ports:
i_clk  input  1  system clock
i_rst  input  1  reset, asynchronous, active-high
i_en  input  32  demod enable; nonzero = run, 0 = idle
i_adc  input  ADC_W  signed photodetector sample, valid every clock
i_freq  input  32  half-period length in clocks
i_wait_cnt  input  32  samples discarded at start of each half-period
i_polarity  input  32  bit0=1 inverts error sign
o_mod  output  1  modulation square wave, 1 = high half
o_err  output  DATA_W  signed demodulated error, held between triggers
o_trig  output  1  1-cycle pulse, o_err updated this cycle
o_status  output  2  state: 0 IDLE, 1 PRIME, 2 RUN

Behaviour:
- One clock domain. Async active-high reset clears everything; applies immediately, including mid-period.
- Reset values: o_mod=0, o_err=0, o_trig=0, o_status=0. Accumulators, counter, shadow registers and en register all clear.
- i_en is registered once (en_r). Other inputs are used directly, except via the shadow registers below.
- Shadow registers freq_s/wait_s load only at period boundaries, so mid-period changes take effect next period.
  - freq_s = clamp(i_freq[15:0], 2..65535).
  - wait_s = min(i_wait_cnt, freq_s-1), so at least 1 sample per half is used.
- IDLE:
  - o_mod=0, cnt=0, accumulators 0, no trig.
  - When en_r nonzero: load shadows, go PRIME, o_mod<=1, cnt<=0.
- PRIME / RUN, per clock, with current half H (= o_mod) and count c:
  - if c >= wait_s: acc_H <= acc_H + sign-extended i_adc.
  - if c == freq_s-1: cnt<=0, o_mod toggles; otherwise cnt<=c+1.
- Period end is the last cycle of the low half (H=0, c=freq_s-1).
  - Difference d = acc_hi - (acc_lo + current sample if included).
  - RUN only: o_err <= (i_polarity[0] ? -d : d), and o_trig=1 for exactly the following cycle.
  - PRIME only: no trig; go RUN. The first period after enable is discarded to settle the loop.
  - Both states: accumulators cleared, shadows reloaded.
- Disable: en_r==0 in PRIME/RUN returns to IDLE on the next edge.
  - The partial period is discarded with no trig.
  - o_err holds its last value.
- Width rules:
  - Accumulators are DATA_W wide, with no overflow for freq_s <= 65535 at ADC_W=14.
  - o_err wraps two's-complement; negating -2^31 is not reachable within these limits.
- o_trig is never asserted in IDLE or PRIME. Minimum trig spacing is 2*freq_s clocks.

Test Plan:
- Timing: i_freq=4, i_wait_cnt=1, i_en 0->1 sampled at edge t0 -> PRIME with o_mod=1 from t0+1; o_mod toggles every 4 clocks; first o_trig rises at edge t0+17 and repeats every 8 clocks.
- Antiphase signal: i_adc=+100 when o_mod=1, -100 when o_mod=0, freq=4, wait=1 -> o_err=600 at every trig; with i_polarity=1 -> o_err=-600.
- Flat signal: constant i_adc=100 -> o_err=0; with i_adc=-8192 and freq=65535, wait=0 -> o_err=0 with no overflow.
- Clamps: i_freq=1 -> half period 2 clocks; i_wait_cnt=10 with freq=4 -> only the c=3 sample is used (antiphase ±100 gives o_err=200).
- Mid-period changes: change i_freq 4->6 mid-period -> the current period completes with 4, the next uses 6. Deassert i_en mid-period -> IDLE, o_mod=0, no trig, o_err holds.
- Reset mid-run: pulse i_rst while o_mod=1 -> o_mod, o_err, o_trig go to 0 asynchronously and o_status=0; after release with i_en=1, PRIME restarts from cnt=0.

Source files
------------

// File: rtl/fog_err_demod.sv
// Closed-loop FOG error demodulator.
// Drives the square-wave bias modulation, integrates ADC samples over the
// high and low half-periods, and once per full period publishes the signed
// half-period difference on o_err with a one-cycle o_trig qualifier.
module fog_err_demod #(
    parameter int ADC_W  = 14,
    parameter int DATA_W = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [31:0]              i_en,
    input  logic signed [ADC_W-1:0]  i_adc,
    input  logic [31:0]              i_freq,
    input  logic [31:0]              i_wait_cnt,
    input  logic [31:0]              i_polarity,
    output logic                     o_mod,
    output logic signed [DATA_W-1:0] o_err,
    output logic                     o_trig,
    output logic [1:0]               o_status
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                   state;
    logic                     en_r;
    logic [15:0]              cnt;
    logic [15:0]              freq_s;
    logic [15:0]              wait_s;
    logic signed [DATA_W-1:0] acc_hi;
    logic signed [DATA_W-1:0] acc_lo;

    logic [15:0]              freq_ld;
    logic [15:0]              wait_ld;
    logic signed [DATA_W-1:0] smp;
    logic signed [DATA_W-1:0] acc_lo_fin;
    logic signed [DATA_W-1:0] diff;
    logic                     use_smp;
    logic                     last_cyc;

    // Only the low half of i_freq and bit 0 of i_polarity carry meaning.
    logic unused_bits;
    assign unused_bits = ^{i_freq[31:16], i_polarity[31:1]};

    assign o_status = state;

    // Shadow-register load values and per-cycle datapath terms.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        freq_ld    = (i_freq[15:0] < 16'd2) ? 16'd2 : i_freq[15:0];
        wait_ld    = (i_wait_cnt > {16'd0, freq_ld - 16'd1}) ? (freq_ld - 16'd1)
                                                              : i_wait_cnt[15:0];
        use_smp    = (cnt >= wait_s);
        last_cyc   = (cnt == freq_s - 16'd1);
        smp        = use_smp ? {{(DATA_W-ADC_W){i_adc[ADC_W-1]}}, i_adc} : '0;
        acc_lo_fin = acc_lo + smp;
        diff       = acc_hi - acc_lo_fin;
    end

    // Modulation sequencer, half-period integration and error publication.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            en_r   <= 1'b0;
            cnt    <= '0;
            freq_s <= '0;
            wait_s <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            o_mod  <= 1'b0;
            o_err  <= '0;
            o_trig <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            en_r   <= |i_en;
            o_trig <= 1'b0;
            case (state)
                ST_IDLE: begin
                    o_mod  <= 1'b0;
                    cnt    <= '0;
                    acc_hi <= '0;
                    acc_lo <= '0;
                    if (en_r) begin
                        freq_s <= freq_ld;
                        wait_s <= wait_ld;
                        o_mod  <= 1'b1;
                        state  <= ST_PRIME;
                    end
                end
                default: begin
                    if (!en_r) begin
                        // Partial period is dropped; o_err keeps its last value.
                        state  <= ST_IDLE;
                        o_mod  <= 1'b0;
                        cnt    <= '0;
                        acc_hi <= '0;
                        acc_lo <= '0;
                    end else begin
                        if (o_mod) begin
                            acc_hi <= acc_hi + smp;
                        end else begin
                            acc_lo <= acc_lo_fin;
                        end
                        if (last_cyc) begin
                            cnt   <= '0;
                            o_mod <= ~o_mod;
                            if (!o_mod) begin
                                // Period boundary: publish (RUN only), restart integration.
                                acc_hi <= '0;
                                acc_lo <= '0;
                                freq_s <= freq_ld;
                                wait_s <= wait_ld;
                                if (state == ST_RUN) begin
                                    o_err  <= i_polarity[0] ? -diff : diff;
                                    o_trig <= 1'b1;
                                end
                                state <= ST_RUN;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fog_err_demod.sv
// Self-checking bench for fog_err_demod: drives half-period sample patterns
// from an independent timing model and checks modulation, status, trigger
// timing and the published error through a scoreboard queue.
module tb_fog_err_demod;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b1;
    logic [31:0]        i_en = '0;
    logic signed [13:0] i_adc = '0;
    logic [31:0]        i_freq = 32'd4;
    logic [31:0]        i_wait_cnt = 32'd1;
    logic [31:0]        i_polarity = '0;
    logic               o_mod;
    logic signed [31:0] o_err;
    logic               o_trig;
    logic [1:0]         o_status;

    int n_cmp = 0;
    int n_bad = 0;
    logic signed [31:0] exp_q[$];

    fog_err_demod #(.ADC_W(14), .DATA_W(32)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_adc      (i_adc),
        .i_freq     (i_freq),
        .i_wait_cnt (i_wait_cnt),
        .i_polarity (i_polarity),
        .o_mod      (o_mod),
        .o_err      (o_err),
        .o_trig     (o_trig),
        .o_status   (o_status)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Enable the demodulator and run np full periods; period p uses f1 from
    // period sw onward (i_freq switched mid-period sw-1). Then run 'tail'
    // cycles into the next period and disable.
    task automatic run_periods(input string name, input int np, input int f0, input int f1,
                               input int sw, input int wt, input bit pol,
                               input int hi_v, input int lo_v, input int tail);
        int f, w, v;
        longint s_hi, s_lo, d;
        logic exp_trig, exp_mod;
        logic [1:0] exp_st;
        logic signed [31:0] e, last_err, got;
        last_err = '0;
        exp_trig = 1'b0;
        @(negedge i_clk);
        i_rst      = 1'b0;
        i_freq     = f0;
        i_wait_cnt = wt;
        i_polarity = pol ? 32'h0000_0001 : 32'hFFFF_FFFE;
        i_en       = 32'h0001_0000;
        @(negedge i_clk);
        n_cmp++;
        if (o_status !== 2'd0 || o_mod !== 1'b0) begin
            n_bad++;
            $display("FAIL %s pre_prime: status=%0d mod=%b want status=0 mod=0", name, o_status, o_mod);
        end
        for (int p = 0; p < np; p++) begin
            f = (p < sw) ? f0 : f1;
            if (f < 2) f = 2;
            w = (wt > f - 1) ? f - 1 : wt;
            s_hi = 0;
            s_lo = 0;
            exp_st = (p == 0) ? 2'd1 : 2'd2;
            for (int h = 1; h >= 0; h--) begin
                exp_mod = (h == 1);
                for (int c = 0; c < f; c++) begin
                    @(negedge i_clk);
                    n_cmp++;
                    if (o_mod !== exp_mod) begin
                        n_bad++;
                        $display("FAIL %s mod p%0d c%0d: got %b want %b", name, p, c, o_mod, exp_mod);
                    end
                    n_cmp++;
                    if (o_status !== exp_st) begin
                        n_bad++;
                        $display("FAIL %s status p%0d c%0d: got %0d want %0d", name, p, c, o_status, exp_st);
                    end
                    n_cmp++;
                    if (o_trig !== exp_trig) begin
                        n_bad++;
                        $display("FAIL %s trig p%0d h%0d c%0d: got %b want %b", name, p, h, c, o_trig, exp_trig);
                    end
                    if (o_trig === 1'b1) begin
                        n_cmp++;
                        if (exp_q.size() == 0) begin
                            n_bad++;
                            $display("FAIL %s err: trig with empty scoreboard, got %0d", name, o_err);
                        end else begin
                            e = exp_q.pop_front();
                            got = o_err;
                            if (got !== e) begin
                                n_bad++;
                                $display("FAIL %s err p%0d: got %0d want %0d", name, p, got, e);
                            end
                        end
                    end
                    exp_trig = 1'b0;
                    if (p == sw - 1 && h == 1 && c == 1) i_freq = f1;
                    v = (h == 1) ? hi_v : lo_v;
                    i_adc = v[13:0];
                    if (c >= w) begin
                        if (h == 1) s_hi += v;
                        else        s_lo += v;
                    end
                end
            end
            if (p >= 1) begin
                d = s_hi - s_lo;
                if (pol) d = -d;
                e = d[31:0];
                exp_q.push_back(e);
                last_err = e;
                exp_trig = 1'b1;
            end
        end
        for (int k = 0; k <= tail; k++) begin
            @(negedge i_clk);
            n_cmp++;
            if (o_trig !== exp_trig) begin
                n_bad++;
                $display("FAIL %s tail_trig k%0d: got %b want %b", name, k, o_trig, exp_trig);
            end
            if (o_trig === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s err: trig with empty scoreboard, got %0d", name, o_err);
                end else begin
                    e = exp_q.pop_front();
                    got = o_err;
                    if (got !== e) begin
                        n_bad++;
                        $display("FAIL %s err last: got %0d want %0d", name, got, e);
                    end
                end
            end
            exp_trig = 1'b0;
            i_adc = hi_v[13:0];
            if (k == tail) i_en = '0;
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            n_cmp++;
            if (o_trig !== 1'b0) begin
                n_bad++;
                $display("FAIL %s disable_trig: got %b want 0", name, o_trig);
            end
        end
        n_cmp++;
        if (o_status !== 2'd0 || o_mod !== 1'b0) begin
            n_bad++;
            $display("FAIL %s disable_idle: status=%0d mod=%b want status=0 mod=0", name, o_status, o_mod);
        end
        n_cmp++;
        if (o_err !== last_err) begin
            n_bad++;
            $display("FAIL %s err_hold: got %0d want %0d", name, o_err, last_err);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s missing_trig: %0d expected results never produced", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_en  = 32'd1;
        #1;
        n_cmp++;
        if (o_mod !== 1'b0 || o_err !== 32'sd0 || o_trig !== 1'b0 || o_status !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_values: mod=%b err=%0d trig=%b status=%0d want all 0", o_mod, o_err, o_trig, o_status);
        end
        repeat (3) @(negedge i_clk);
        n_cmp++;
        if (o_mod !== 1'b0 || o_status !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_hold: mod=%b status=%0d want 0/0", o_mod, o_status);
        end
        i_rst = 1'b0;
        i_en  = '0;
        repeat (4) @(negedge i_clk);
        n_cmp++;
        if (o_mod !== 1'b0 || o_status !== 2'd0 || o_trig !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_when_disabled: mod=%b status=%0d trig=%b want 0", o_mod, o_status, o_trig);
        end
    endtask

    task automatic test_antiphase();
        run_periods("antiphase", 4, 4, 4, 1, 1, 1'b0, 100, -100, 1);
        run_periods("antiphase_pol", 3, 4, 4, 1, 1, 1'b1, 100, -100, 2);
    endtask

    task automatic test_flat();
        run_periods("flat_100", 3, 4, 4, 1, 1, 1'b0, 100, 100, 1);
        run_periods("flat_min_long", 2, 5000, 5000, 1, 0, 1'b0, -8192, -8192, 1);
        run_periods("full_scale", 2, 3000, 3000, 1, 0, 1'b0, 8191, -8192, 1);
    endtask

    task automatic test_clamps();
        run_periods("freq_clamp", 4, 1, 1, 1, 0, 1'b0, 100, -100, 1);
        run_periods("wait_clamp", 3, 4, 4, 1, 10, 1'b0, 100, -100, 1);
    endtask

    task automatic test_freq_change();
        run_periods("freq_change", 4, 4, 6, 2, 1, 1'b0, 100, -100, 3);
    endtask

    task automatic test_reset_mid_run();
        logic exp_mod;
        @(negedge i_clk);
        i_freq     = 32'd4;
        i_wait_cnt = 32'd1;
        i_polarity = '0;
        i_en       = 32'd1;
        @(negedge i_clk);
        for (int i = 0; i <= 18; i++) begin
            @(negedge i_clk);
            exp_mod = ((i % 8) < 4);
            if (i == 16) begin
                n_cmp++;
                if (o_trig !== 1'b1 || o_err !== 32'sd600) begin
                    n_bad++;
                    $display("FAIL rst_mid pre_trig: trig=%b err=%0d want 1/600", o_trig, o_err);
                end
            end
            i_adc = exp_mod ? 14'sd100 : -14'sd100;
        end
        n_cmp++;
        if (o_mod !== 1'b1 || o_err !== 32'sd600 || o_status !== 2'd2) begin
            n_bad++;
            $display("FAIL rst_mid pre_state: mod=%b err=%0d status=%0d want 1/600/2", o_mod, o_err, o_status);
        end
        #2;
        i_rst = 1'b1;
        #1;
        n_cmp++;
        if (o_mod !== 1'b0 || o_err !== 32'sd0 || o_trig !== 1'b0 || o_status !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_mid async_clear: mod=%b err=%0d trig=%b status=%0d want all 0",
                     o_mod, o_err, o_trig, o_status);
        end
        run_periods("after_reset", 2, 4, 4, 1, 1, 1'b0, 100, -100, 1);
    endtask

    initial begin
        test_reset();
        test_antiphase();
        test_flat();
        test_clamps();
        test_freq_change();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
